// File: rtl/mac4x4_feeder.sv
// mac4x4_feeder: loads 4 weight rows into the MAC4x4 array, then streams diagonally skewed activation
// vectors and pulses done once the array has drained. Define FEEDER_WREUSE_EN to let a job start
// straight from IDLE with an activation vector, reusing the weights already resident in the array.
module mac4x4_feeder #(
    parameter int N          = 4,
    parameter int DW         = 8,
    parameter int DONE_DELAY = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_wvalid,
    output logic            s_wready,
    input  logic [N*DW-1:0] s_wdata,
    input  logic            s_avalid,
    output logic            s_aready,
    input  logic [N*DW-1:0] s_adata,
    input  logic            s_alast,
    output logic            w_load,
    output logic [1:0]      wrow,
    output logic [N*DW-1:0] wdata,
    output logic [N*DW-1:0] idata,
    output logic [N-1:0]    icol_valid,
    output logic            busy,
    output logic            done,
    output logic [15:0]     vec_cnt
);
    localparam int BW = N * DW;
    localparam logic [7:0] DRAIN_LAST = 8'(N - 2 + DONE_DELAY);

    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

    state_t        state;
    logic [1:0]    row_cnt;
    logic [7:0]    drain_cnt;
    logic          w_acc;
    logic          a_acc;
    logic [BW-1:0] line_in;
    logic [BW-1:0] sk_data [N-1];
    logic [N-2:0]  sk_vld;

    // handshakes: weights are taken before streaming, activations only while streaming (or from IDLE when reusing weights)
    always_comb begin
        s_wready = (state == IDLE) || (state == LOAD_W);
`ifdef FEEDER_WREUSE_EN
        s_aready = (state == STREAM) || (state == IDLE && !s_wvalid);
`else
        s_aready = (state == STREAM);
`endif
        w_acc    = s_wvalid && s_wready;
        a_acc    = s_avalid && s_aready;
        line_in  = a_acc ? s_adata : '0;
        busy     = (state != IDLE);
    end

    // job sequencing, weight write-through, vector count and drain timer
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row_cnt   <= '0;
            drain_cnt <= '0;
            w_load    <= 1'b0;
            wrow      <= '0;
            wdata     <= '0;
            done      <= 1'b0;
            vec_cnt   <= '0;
        end else begin
            w_load <= w_acc;
            done   <= 1'b0;
            if (w_acc) begin
                wrow    <= row_cnt;
                wdata   <= s_wdata;
                row_cnt <= row_cnt + 2'd1;
            end
            if (a_acc)
                vec_cnt <= (state == IDLE) ? 16'd1 : vec_cnt + {15'd0, vec_cnt != 16'hFFFF};
            case (state)
                IDLE: begin
                    if (w_acc) begin
                        state   <= LOAD_W;
                        vec_cnt <= '0;
                    end else if (a_acc) begin
                        state <= s_alast ? DRAIN : STREAM;
                    end
                end
                LOAD_W: if (w_acc && row_cnt == 2'd3) state <= STREAM;
                STREAM: if (a_acc && s_alast) state <= DRAIN;
                DRAIN: begin
                    drain_cnt <= (drain_cnt == DRAIN_LAST) ? 8'd0 : drain_cnt + 8'd1;
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // skew line: column j of a vector reaches idata j+1 cycles after acceptance; idle cycles travel as zero bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            sk_data    <= '{default: '0};
            sk_vld     <= '0;
            idata      <= '0;
            icol_valid <= '0;
        end else begin
            sk_data[0] <= line_in;
            sk_vld[0]  <= a_acc;
            for (int i = 1; i < N - 1; i++) begin
                sk_data[i] <= sk_data[i-1];
                sk_vld[i]  <= sk_vld[i-1];
            end
            idata[BW-1 -: DW] <= line_in[BW-1 -: DW];
            icol_valid[0]     <= a_acc;
            for (int j = 1; j < N; j++) begin
                idata[BW-1-DW*j -: DW] <= sk_data[j-1][BW-1-DW*j -: DW];
                icol_valid[j]          <= sk_vld[j-1];
            end
        end
    end
endmodule
